// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR datapath: default sample width,
// default input FIFO depth and the matching pointer width.
package fir_pkg;

  localparam int FIR_DATA_W = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  typedef logic [FIR_DATA_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Register-array storage for the input sample FIFO. It has a synchronous
// write port and an asynchronous read port, so the FIFO can show its head entry.
module sample_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // No reset on the storage: only the pointers and count in the parent are cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sample_input_fifo.sv
// Show-ahead input sample FIFO feeding control_fsm. When FIFO_OVERFLOW_DETECT_EN
// is defined, the block also has a sticky overflow flag for pushes dropped while full.
module sample_input_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PushIn,
  input  logic [DATA_W-1:0]        DataIn,
  input  logic                     fifoPullOut,
  output logic [DATA_W-1:0]        DataOut,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   level
`ifdef FIFO_OVERFLOW_DETECT_EN
  ,
  output logic                     overflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));

  // A same-cycle pull frees the slot, so a push into a full FIFO is accepted.
  assign w_push = PushIn && (!w_full || fifoPullOut);
  assign w_pop  = fifoPullOut && !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  sample_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wp),
    .wdata (DataIn),
    .raddr (r_rp),
    .rdata (DataOut)
  );

  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign level      = r_cnt;

`ifdef FIFO_OVERFLOW_DETECT_EN
  logic r_overflow;

  // Sticky until reset; only a push that is really dropped sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (PushIn && w_full && !fifoPullOut) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_sample_input_fifo.sv
// Self-checking bench for sample_input_fifo, with directed scenarios and a random
// phase, checked against a queue-based model. FIFO_OVERFLOW_DETECT_EN matches the DUT build.
module tb_sample_input_fifo;
  import fir_pkg::*;

  localparam int DW    = FIR_DATA_W;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          PushIn = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic          fifoPullOut = 1'b0;
  logic [DW-1:0] DataOut;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] level;
`ifdef FIFO_OVERFLOW_DETECT_EN
  logic          overflow;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the stored samples in arrival order, plus the sticky error flag.
  sample_t q[$];
  bit      mOvf = 1'b0;

  sample_input_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .PushIn      (PushIn),
    .DataIn      (DataIn),
    .fifoPullOut (fifoPullOut),
    .DataOut     (DataOut),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .level       (level)
`ifdef FIFO_OVERFLOW_DETECT_EN
    ,
    .overflow    (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one clock with the given inputs, then update the model. Outputs settle at #1 after the edge.
  task automatic cycle(input logic push, input sample_t d, input logic pull);
    bit pushOk, popOk;
    PushIn      = push;
    DataIn      = d;
    fifoPullOut = pull;
    @(posedge clk);
    #1;
    popOk  = pull && (q.size() > 0);
    pushOk = push && ((q.size() < DEPTH) || pull);
    if (push && q.size() == DEPTH && !pull) mOvf = 1'b1;
    if (popOk) void'(q.pop_front());
    if (pushOk) q.push_back(d);
    PushIn      = 1'b0;
    fifoPullOut = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || level !== '0) begin
      errors++;
      $display("[TB] FAIL reset_flags: actual empty=%b full=%b level=%0d required empty=1 full=0 level=0",
               fifo_empty, fifo_full, level);
    end
`ifdef FIFO_OVERFLOW_DETECT_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overflow: actual=%b required=0", overflow);
    end
`endif
    q.delete();
    mOvf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || level !== '0) begin
        errors++;
        $display("[TB] FAIL idle_flags[%0d]: actual empty=%b full=%b level=%0d required empty=1 full=0 level=0",
                 i, fifo_empty, fifo_full, level);
      end
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 32'h11, 1'b0);
    checks++;
    if (fifo_empty !== 1'b0 || DataOut !== 32'h11) begin
      errors++;
      $display("[TB] FAIL first_write: actual empty=%b data=%h required empty=0 data=11", fifo_empty, DataOut);
    end
    cycle(1'b1, 32'h22, 1'b0);
    cycle(1'b1, 32'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (DataOut !== DW'(32'h11 * (i + 1)) || level !== LW'(3 - i)) begin
        errors++;
        $display("[TB] FAIL basic_pull[%0d]: actual data=%h level=%0d required data=%h level=%0d",
                 i, DataOut, level, 32'h11 * (i + 1), 3 - i);
      end
      cycle(1'b0, '0, 1'b1);
    end
    checks++;
    if (fifo_empty !== 1'b1 || level !== '0) begin
      errors++;
      $display("[TB] FAIL basic_drained: actual empty=%b level=%0d required empty=1 level=0", fifo_empty, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, sample_t'(i), 1'b0);
    cycle(1'b1, 32'hAA, 1'b0);
    checks++;
    if (fifo_full !== 1'b1 || level !== LW'(DEPTH)) begin
      errors++;
      $display("[TB] FAIL full_flags: actual full=%b level=%0d required full=1 level=%0d", fifo_full, level, DEPTH);
    end
`ifdef FIFO_OVERFLOW_DETECT_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: actual=%b required=1", overflow);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (DataOut !== sample_t'(i)) begin
        errors++;
        $display("[TB] FAIL drain[%0d]: actual=%h required=%h", i, DataOut, i);
      end
      cycle(1'b0, '0, 1'b1);
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_lost: actual empty=%b required empty=1 (0xAA must be dropped)", fifo_empty);
    end
  endtask

  task automatic test_full_push_pull();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, sample_t'(i), 1'b0);
    cycle(1'b1, 32'hBB, 1'b1);
    checks++;
    if (level !== LW'(DEPTH) || DataOut !== 32'h01 || fifo_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_push_pull: actual level=%0d data=%h full=%b required level=%0d data=01 full=1",
               level, DataOut, fifo_full, DEPTH);
    end
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (DataOut !== 32'hBB || level !== 1) begin
      errors++;
      $display("[TB] FAIL full_push_pull_tail: actual data=%h level=%0d required data=bb level=1", DataOut, level);
    end
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    sample_t got[$];
    int      sent = 0;
    int      maxLevel = 0;
    for (int c = 0; c < 40; c++) begin
      logic doPull;
      doPull = (c >= 2);
      if (doPull && !fifo_empty) got.push_back(DataOut);
      if (sent >= 20 && fifo_empty) break;
      cycle(sent < 20, sample_t'(sent), doPull);
      if (sent < 20) sent++;
      if (int'(level) > maxLevel) maxLevel = int'(level);
      checks++;
      if (level !== LW'(q.size())) begin
        errors++;
        $display("[TB] FAIL wrap_level[%0d]: actual=%0d required=%0d", c, level, q.size());
      end
    end
    checks++;
    if (got.size() != 20 || maxLevel > 2) begin
      errors++;
      $display("[TB] FAIL wrap_count: actual count=%0d maxlevel=%0d required count=20 maxlevel<=2",
               got.size(), maxLevel);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== sample_t'(i)) begin
        errors++;
        $display("[TB] FAIL wrap_order[%0d]: actual=%h required=%h", i, got[i], i);
      end
    end
  endtask

  task automatic test_pull_empty();
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (fifo_empty !== 1'b1 || level !== '0) begin
      errors++;
      $display("[TB] FAIL pull_empty: actual empty=%b level=%0d required empty=1 level=0", fifo_empty, level);
    end
    cycle(1'b1, 32'h5A, 1'b1);
    checks++;
    if (DataOut !== 32'h5A || level !== 1 || fifo_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_after_empty: actual data=%h level=%0d required data=5a level=1", DataOut, level);
    end
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 99) < 55, sample_t'($urandom), $urandom_range(0, 99) < 50);
      checks++;
      if (level !== LW'(q.size()) || fifo_empty !== (q.size() == 0) || fifo_full !== (q.size() == DEPTH)) begin
        errors++;
        $display("[TB] FAIL rand_flags[%0d]: actual level=%0d empty=%b full=%b required level=%0d",
                 c, level, fifo_empty, fifo_full, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (DataOut !== q[0]) begin
          errors++;
          $display("[TB] FAIL rand_data[%0d]: actual=%h required=%h", c, DataOut, q[0]);
        end
      end
`ifdef FIFO_OVERFLOW_DETECT_EN
      checks++;
      if (overflow !== mOvf) begin
        errors++;
        $display("[TB] FAIL rand_overflow[%0d]: actual=%b required=%b", c, overflow, mOvf);
      end
`endif
    end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 5; i++) cycle(1'b1, sample_t'($urandom), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_empty !== 1'b1 || level !== '0 || fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: actual empty=%b level=%0d required empty=1 level=0", fifo_empty, level);
    end
    q.delete();
    mOvf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 32'hC3, 1'b0);
    checks++;
    if (DataOut !== 32'hC3 || level !== 1) begin
      errors++;
      $display("[TB] FAIL post_reset_push: actual data=%h level=%0d required data=c3 level=1", DataOut, level);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pull();
    test_wrap();
    test_pull_empty();
    test_random();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_input_fifo.md
# sample_input_fifo

Input sample buffer on the write side of the FIR datapath's pull handshake. Absorbs `PushIn` samples from the external source and presents them, show-ahead, to `control_fsm`. It drives `fifo_empty` to the FSM, and `control_fsm` consumes one sample per `fifoPullOut` pulse. Sits between the chip input pins and the multiplier-mux/accumulate pipeline.

## Interface
- `DATA_W`, 32: sample width in bits.
- `DEPTH`, 8: entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `PushIn` input 1: write strobe; one sample per cycle while high.
- `DataIn` input `DATA_W`: sample written when `PushIn` is accepted.
- `fifoPullOut` input 1: pop strobe from `control_fsm`.
- `DataOut` output `DATA_W`: head sample; valid whenever `fifo_empty`=0.
- `fifo_empty` output 1: no stored samples.
- `fifo_full` output 1: `DEPTH` samples stored.
- `level` output `$clog2(DEPTH)+1`: stored sample count.
- `overflow` output 1: sticky push-while-full error. Present only with `FIFO_OVERFLOW_DETECT_EN`.

## Operation
- Circular buffer with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, wrapping from `DEPTH-1` to 0.
- Count register `cnt`, range 0..`DEPTH`.
- Outputs are derived as follows:
  - `fifo_empty` = (`cnt`==0).
  - `fifo_full` = (`cnt`==`DEPTH`).
  - `level` = `cnt`.
- Push accept condition: `PushIn && (!fifo_full || fifoPullOut)`. A simultaneous pull frees the slot, so a push while full with a same-cycle pull is accepted.
- Pop accept condition: `fifoPullOut && !fifo_empty`. A pull while empty is ignored: no pointer or count change and no error.
- Count update:
  - Push only: `cnt`+1.
  - Pop only: `cnt`-1.
  - Both accepted: `cnt` unchanged; both pointers advance.
  - Push and pull on an empty FIFO: only the push takes effect, `cnt` 0→1, and the pull is lost.
- Push while full with no pull: sample dropped, state unchanged.
- `DataOut` = `mem[rp]`, a combinational read of the storage (show-ahead). The value is undefined while empty, and `control_fsm` must not sample it then.
- Storage holds no reset value; only the pointers, count and flags reset.

## Timing
- Reset (async assert, synchronous deassert by the system) sets:
  - `wp`=0, `rp`=0, `cnt`=0.
  - `fifo_empty`=1, `fifo_full`=0, `level`=0, `overflow`=0.
- Write latency: a sample accepted at edge N is visible on `DataOut` after edge N if the FIFO was empty. `fifo_empty` falls after edge N, so there is no fall-through within the same cycle.
- Pop: after the edge on which `fifoPullOut` is accepted, `DataOut` shows the next entry.
- Flags change only on `clk` edges; there is no combinational path from `PushIn` or `fifoPullOut` to any flag.
- `control_fsm` may hold `fifoPullOut` high continuously. This pops one sample per cycle until `fifo_empty` rises.
- Reset asserted mid-stream: contents are discarded immediately and `fifo_empty`=1 is seen without waiting for a clock.

## Configuration
- `FIFO_OVERFLOW_DETECT_EN` defined:
  - `overflow` port exists.
  - It sets on any cycle with `PushIn` && `fifo_full` && !`fifoPullOut`.
  - It stays set until `reset`.
- Not defined:
  - Port and register are absent.
  - Dropped pushes are silent.
  - All other behaviour is identical.

## Structure
- Shared package `fir_pkg`:
  - `DATA_W` default constant.
  - `sample_t` typedef (`logic [DATA_W-1:0]`).
  - `FIFO_DEPTH` default.
  - Pointer-width helper constant.
- One sub-module, `sample_fifo_mem`:
  - `DEPTH`×`DATA_W` register array.
  - Synchronous write port (`we`, `waddr`, `wdata`).
  - Asynchronous read port (`raddr`, `rdata`).
- The top holds the pointers, count, flags and the optional overflow logic.

## Test plan
- Reset then idle: after `reset` drops, `fifo_empty`=1, `fifo_full`=0, `level`=0 for 10 cycles.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pull 3 times:
  - `DataOut` reads 0x11, 0x22, 0x33 in order.
  - `level` goes 3→0 and `fifo_empty` returns to 1.
- Fill to 8 entries (0x00..0x07), then push 0xAA with no pull:
  - `fifo_full`=1 and `level`=8.
  - 0xAA is dropped; draining yields 0x00..0x07 only.
  - `overflow`=1 when `FIFO_OVERFLOW_DETECT_EN` is defined.
- Full FIFO, push 0xBB and pull in the same cycle:
  - `level` stays 8 and `DataOut` advances to 0x01.
  - After 7 more pulls, `DataOut`=0xBB.
- Wrap-around: stream 20 samples (0..19) with push and pull overlapping from cycle 2. Output order is 0..19 with no loss and `level` never exceeds 2.
- Pull while empty, then push 0x5A:
  - No state change during the pull.
  - After the push, `DataOut`=0x5A and `level`=1.
  - Asserting `reset` mid-burst forces `fifo_empty`=1 asynchronously.
